// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps micro-ops per opcode, tracks prefix pages,
// forms the ROM address and gates the fetched control word.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   opcode        instruction register contents
//   flags         ALU flags folded into the ROM address
//   stall         freezes step/page/step_ovf (wait states)
//   ctrl_en       1 = drive uword onto control_word, 0 = drive CW_IDLE
//   uaddr         ROM address {page, flags, opcode, step}
//   uword         ROM data, combinational from uaddr
//   control_word  gated control word to the datapath
//   step, page    current micro-step and opcode page
//   step_ovf      sticky: step counter wrapped without a step reset
module microcode_sequencer #(
    parameter int OPCODE_W = 8,
    parameter int FLAGS_W  = 4,
    parameter int STEP_W   = 3,
    parameter int PAGES    = 4,
    parameter int CW_W     = 32,
    parameter int SR_BIT   = 0,
    parameter int EXT_BIT  = 1,
    parameter logic [CW_W-1:0] CW_IDLE = 32'h17ff58ff,
    localparam int PAGE_W  = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int UADDR_W = PAGE_W + FLAGS_W + OPCODE_W + STEP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAGS_W-1:0]  flags,
    input  logic                stall,
    input  logic                ctrl_en,
    output logic [UADDR_W-1:0]  uaddr,
    input  logic [CW_W-1:0]     uword,
    output logic [CW_W-1:0]     control_word,
    output logic [STEP_W-1:0]   step,
    output logic [PAGE_W-1:0]   page,
    output logic                step_ovf
);

    localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

    logic                sr;
    logic                ex;
    logic                ovf_hit;
    logic [STEP_W-1:0]   step_nxt;
    logic [PAGE_W-1:0]   page_nxt;

    // SR/EX come from the raw ROM word so gating the bus never
    // disturbs sequencing.
    assign sr = uword[SR_BIT];
    assign ex = (PAGES > 1) && uword[EXT_BIT];

    assign uaddr        = {page, flags, opcode, step};
    assign control_word = ctrl_en ? uword : CW_IDLE;

    always_comb begin
        step_nxt = step + STEP_W'(1);
        ovf_hit  = 1'b0;
        page_nxt = page;
        if (sr) begin
            step_nxt = '0;
        end else if (step == STEP_MAX) begin
            ovf_hit = 1'b1;
        end
        // Prefix advance wins over the page clear: SR+EX ends the
        // prefix instruction but keeps the new page for the next fetch.
        if (ex) begin
            if (page != PAGE_MAX) begin
                page_nxt = page + PAGE_W'(1);
            end
        end else if (sr) begin
            page_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step     <= '0;
            page     <= '0;
            step_ovf <= 1'b0;
        end else if (!stall) begin
            step <= step_nxt;
            page <= page_nxt;
            if (ovf_hit) begin
                step_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_microcode_sequencer;

    localparam int OW = 8;
    localparam int FW = 4;
    localparam int SW = 3;
    localparam int NP = 4;
    localparam int CW = 32;
    localparam int PW = 2;
    localparam int AW = PW + FW + OW + SW;
    localparam logic [31:0] IDLE = 32'h17ff58ff;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [OW-1:0] opcode = '0;
    logic [FW-1:0] flags = '0;
    logic          stall = 1'b0;
    logic          ctrl_en = 1'b1;
    logic [AW-1:0] uaddr;
    logic [CW-1:0] uword = '0;
    logic [CW-1:0] control_word;
    logic [SW-1:0] step;
    logic [PW-1:0] page;
    logic          step_ovf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_step = 0;
    int m_page = 0;
    int m_ovf  = 0;

    microcode_sequencer #(
        .OPCODE_W(OW), .FLAGS_W(FW), .STEP_W(SW), .PAGES(NP),
        .CW_W(CW), .SR_BIT(0), .EXT_BIT(1), .CW_IDLE(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flags(flags),
        .stall(stall), .ctrl_en(ctrl_en), .uaddr(uaddr),
        .uword(uword), .control_word(control_word),
        .step(step), .page(page), .step_ovf(step_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: step counts modulo 2^SW, page saturates at NP-1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_step = 0;
            m_page = 0;
            m_ovf  = 0;
        end else if (!stall) begin
            if (uword[0]) begin
                m_step = 0;
            end else if (m_step == (1 << SW) - 1) begin
                m_step = 0;
                m_ovf  = 1;
            end else begin
                m_step = m_step + 1;
            end
            if (uword[1]) begin
                m_page = (m_page + 1 > NP - 1) ? NP - 1 : m_page + 1;
            end else if (uword[0]) begin
                m_page = 0;
            end
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic longint exp_addr();
        longint a;
        a = longint'(m_page) * (longint'(1) << (FW + OW + SW));
        a += longint'(flags) * (longint'(1) << (OW + SW));
        a += longint'(opcode) * (longint'(1) << SW);
        a += longint'(m_step);
        return a;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("step", step, m_step);
            check("page", page, m_page);
            check("step_ovf", step_ovf, m_ovf);
            check("uaddr", uaddr, exp_addr());
            check("control_word", control_word,
                  ctrl_en ? uword : IDLE);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input int s, input int p, input int o);
        check("pin_step", step, s);
        check("pin_page", page, p);
        check("pin_ovf", step_ovf, o);
    endtask

    initial begin
        tick();
        pin(0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        opcode = 8'h01;
        flags = '0;
        uword = '0;
        #1;
        check("addr0", uaddr, 17'h00008);
        tick();
        check("addr1", uaddr, 17'h00009);
        tick();
        check("addr2", uaddr, 17'h0000A);
        pin(2, 0, 0);
        uword = 32'h1;
        tick();
        pin(0, 0, 0);

        uword = 32'h0;
        tick();
        uword = 32'h2;
        tick();
        pin(2, 1, 0);
        uword = 32'h0;
        tick();
        pin(3, 1, 0);
        tick();
        pin(4, 1, 0);
        uword = 32'h1;
        tick();
        pin(0, 0, 0);

        uword = 32'h2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_page", page, (i < 3) ? i + 1 : 3);
        end
        uword = 32'h3;
        tick();
        pin(0, 3, 0);
        uword = 32'h1;
        tick();
        pin(0, 0, 0);

        uword = 32'h0;
        for (int i = 0; i < 7; i++) tick();
        pin(7, 0, 0);
        tick();
        pin(0, 0, 1);
        tick();
        stall = 1'b1;
        uword = 32'h2;
        for (int i = 0; i < 3; i++) tick();
        pin(1, 0, 1);
        stall = 1'b0;
        uword = 32'h0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 pin(0, 0, 0);
        tick();
        rst = 1'b0;

        tick();
        tick();
        uword = 32'h16fd5809;
        ctrl_en = 1'b1;
        #1 check("cw_on", control_word, 32'h16fd5809);
        ctrl_en = 1'b0;
        #1 check("cw_off", control_word, 32'h17ff58ff);
        pin(2, 0, 0);
        tick();
        pin(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[0] = ($urandom_range(0, 5) == 0);
            w[1] = ($urandom_range(0, 3) == 0);
            uword = w;
            opcode = OW'($urandom);
            flags = FW'($urandom);
            ctrl_en = $urandom_range(0, 1) == 1;
            stall = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 60) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
